// File: rtl/simd_alu.sv
// Two-stage pipelined SIMD integer ALU: one op applied across NUM_LANES lanes
// with per-lane mask, pass-through tag and valid/ready on both sides.
module simd_alu #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_LANES  = 4,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [3:0]                      in_op,
   input  logic [NUM_LANES-1:0]            in_mask,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_a,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_b,
   input  logic [TAG_WIDTH-1:0]            in_tag,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_LANES*DATA_WIDTH-1:0] out_result,
   output logic [NUM_LANES-1:0]            out_zero,
   output logic [NUM_LANES-1:0]            out_mask,
   output logic [TAG_WIDTH-1:0]            out_tag,
   output logic                            out_illegal
);

   localparam int SH_W = $clog2(DATA_WIDTH);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,
      OP_AND  = 4'd3,  OP_OR   = 4'd4,  OP_XOR  = 4'd5,
      OP_SLL  = 4'd6,  OP_SRL  = 4'd7,  OP_SRA  = 4'd8,
      OP_SLT  = 4'd9,  OP_SLTU = 4'd10, OP_MIN  = 4'd11,
      OP_MAX  = 4'd12
   } op_e;

   logic                            s1_valid;
   logic [3:0]                      s1_op;
   logic [NUM_LANES-1:0]            s1_mask;
   logic [NUM_LANES*DATA_WIDTH-1:0] s1_a;
   logic [NUM_LANES*DATA_WIDTH-1:0] s1_b;
   logic [TAG_WIDTH-1:0]            s1_tag;

   logic                            s1_illegal;
   logic [NUM_LANES*DATA_WIDTH-1:0] lane_res;
   logic [NUM_LANES-1:0]            lane_zero;
   logic                            advance;

   // S2 may take a new value when it is empty or its current value leaves this cycle.
   assign advance    = !out_valid || out_ready;
   assign in_ready   = advance || !s1_valid;
   assign s1_illegal = (s1_op > OP_MAX);

   function automatic logic [DATA_WIDTH-1:0] lane_op(
      input logic [3:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [SH_W-1:0] sh;
      sh = b[SH_W-1:0];
      case (op)
         OP_ADD:  lane_op = a + b;
         OP_SUB:  lane_op = a - b;
         OP_MUL:  lane_op = a * b;
         OP_AND:  lane_op = a & b;
         OP_OR:   lane_op = a | b;
         OP_XOR:  lane_op = a ^ b;
         OP_SLL:  lane_op = a << sh;
         OP_SRL:  lane_op = a >> sh;
         OP_SRA:  lane_op = $unsigned($signed(a) >>> sh);
         OP_SLT:  lane_op = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: lane_op = {{(DATA_WIDTH-1){1'b0}}, a < b};
         OP_MIN:  lane_op = ($signed(a) < $signed(b)) ? a : b;
         OP_MAX:  lane_op = ($signed(a) < $signed(b)) ? b : a;
         default: lane_op = '0;
      endcase
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      lane_res  = '0;
      lane_zero = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (s1_mask[i] && !s1_illegal) begin
            lane_res[i*DATA_WIDTH +: DATA_WIDTH] =
               lane_op(s1_op, s1_a[i*DATA_WIDTH +: DATA_WIDTH], s1_b[i*DATA_WIDTH +: DATA_WIDTH]);
            lane_zero[i] = (lane_res[i*DATA_WIDTH +: DATA_WIDTH] == '0);
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so both stages see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: data registers are cleared too, so nothing stale is visible after reset.
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_mask  <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_tag   <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op   <= in_op;
            s1_mask <= in_mask;
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_tag  <= in_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_zero    <= '0;
         out_mask    <= '0;
         out_tag     <= '0;
         out_illegal <= 1'b0;
      end else if (advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result  <= lane_res;
            out_zero    <= lane_zero;
            out_mask    <= s1_mask;
            out_tag     <= s1_tag;
            out_illegal <= s1_illegal;
         end
      end
   end

endmodule

// File: tb/tb_simd_alu.sv
// Self-checking bench for simd_alu: directed cases plus a randomized stream
// scored against an arithmetic reference model.
module tb_simd_alu;

   localparam int DW = 16;
   localparam int NL = 4;
   localparam int TW = 4;

   logic            clk;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      in_op;
   logic [NL-1:0]   in_mask;
   logic [NL*DW-1:0] in_a;
   logic [NL*DW-1:0] in_b;
   logic [TW-1:0]   in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [NL*DW-1:0] out_result;
   logic [NL-1:0]   out_zero;
   logic [NL-1:0]   out_mask;
   logic [TW-1:0]   out_tag;
   logic            out_illegal;

   simd_alu #(.DATA_WIDTH(DW), .NUM_LANES(NL), .TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_mask(in_mask),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_mask(out_mask), .out_tag(out_tag), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [NL*DW-1:0] res;
      logic [NL-1:0]    zero;
      logic [NL-1:0]    mask;
      logic [TW-1:0]    tag;
      logic             ill;
   } exp_t;

   exp_t exp_q[$];

   // Reference lane operation, written with plain integer arithmetic.
   function automatic logic [DW-1:0] ref_lane(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint m, ua, ub, sa, sb, r;
      int sh;
      m  = longint'(1) << DW;
      ua = longint'(a);
      ub = longint'(b);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      sh = int'(ub % DW);
      case (op)
         0:  r = (ua + ub) % m;
         1:  r = (ua - ub + m) % m;
         2:  r = (ua * ub) % m;
         3:  r = ua & ub;
         4:  r = ua | ub;
         5:  r = ua ^ ub;
         6:  r = (ua * (longint'(1) << sh)) % m;
         7:  r = ua / (longint'(1) << sh);
         8:  begin r = sa >>> sh; if (r < 0) r = r + m; end
         9:  r = (sa < sb) ? 1 : 0;
         10: r = (ua < ub) ? 1 : 0;
         11: r = (sa < sb) ? ua : ub;
         12: r = (sa > sb) ? ua : ub;
         default: r = 0;
      endcase
      return r[DW-1:0];
   endfunction

   function automatic exp_t model(input logic [3:0] op, input logic [NL-1:0] mask,
                                  input logic [NL*DW-1:0] a, input logic [NL*DW-1:0] b,
                                  input logic [TW-1:0] tag);
      exp_t e;
      logic [DW-1:0] r;
      e.res  = '0;
      e.zero = '0;
      e.mask = mask;
      e.tag  = tag;
      e.ill  = (int'(op) > 12);
      for (int i = 0; i < NL; i++) begin
         if (mask[i] && !e.ill) begin
            r = ref_lane(int'(op), a[i*DW +: DW], b[i*DW +: DW]);
            e.res[i*DW +: DW] = r;
            e.zero[i] = (r == 0);
         end
      end
      return e;
   endfunction

   // Scoreboard: observe both handshakes away from the active edge.
   logic             hold_v = 1'b0;
   logic [NL*DW-1:0] hold_res;
   logic [NL-1:0]    hold_zero, hold_mask;
   logic [TW-1:0]    hold_tag;
   logic             hold_ill;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         hold_v <= 1'b0;
      end else begin
         check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
         if (hold_v)
            check("hold_stable", {out_valid, out_result, out_zero, out_mask, out_tag, out_illegal},
                  {1'b1, hold_res, hold_zero, hold_mask, hold_tag, hold_ill});
         hold_v    <= out_valid && !out_ready;
         hold_res  <= out_result;
         hold_zero <= out_zero;
         hold_mask <= out_mask;
         hold_tag  <= out_tag;
         hold_ill  <= out_illegal;
         if (out_valid && out_ready) begin
            check("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               check("sb_res",  out_result,  exp_q[0].res);
               check("sb_zero", out_zero,    exp_q[0].zero);
               check("sb_mask", out_mask,    exp_q[0].mask);
               check("sb_tag",  out_tag,     exp_q[0].tag);
               check("sb_ill",  out_illegal, exp_q[0].ill);
               void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(in_op, in_mask, in_a, in_b, in_tag));
      end
   end

   task automatic send(input logic [3:0] op, input logic [NL-1:0] mask,
                       input logic [NL*DW-1:0] a, input logic [NL*DW-1:0] b,
                       input logic [TW-1:0] tag);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_mask  = mask;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         if (in_ready && !reset) acc = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("send_accepted", acc, 1);
   endtask

   task automatic expect_out(input string name, input logic [NL*DW-1:0] res,
                             input logic [NL-1:0] zero, input logic ill, input logic [TW-1:0] tag);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check({name, "_valid"}, seen, 1);
      check({name, "_res"}, out_result, res);
      check({name, "_zero"}, out_zero, zero);
      check({name, "_ill"}, out_illegal, ill);
      check({name, "_tag"}, out_tag, tag);
      @(posedge clk); #1;
   endtask

   function automatic logic [NL*DW-1:0] rep(input logic [DW-1:0] x);
      return {NL{x}};
   endfunction

   function automatic logic [NL*DW-1:0] rnd_vec();
      logic [NL*DW-1:0] v;
      for (int i = 0; i < NL; i++) begin
         case ($urandom_range(0, 7))
            0:       v[i*DW +: DW] = '0;
            1:       v[i*DW +: DW] = DW'(16'h8000);
            2:       v[i*DW +: DW] = '1;
            3:       v[i*DW +: DW] = DW'(16'h7FFF);
            default: v[i*DW +: DW] = DW'($urandom);
         endcase
      end
      return v;
   endfunction

   bit rand_done;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_mask = '0; in_a = '0; in_b = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", {out_result, out_zero, out_mask, out_tag, out_illegal}, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Basic add with exact latency.
      send(4'd0, 4'hF, {16'h0000, 16'h0005, 16'hFFFF, 16'h0001},
                       {16'h0000, 16'h0005, 16'h0001, 16'h0002}, 4'd1);
      @(negedge clk);
      check("add_lat1_valid", out_valid, 0);
      @(negedge clk);
      check("add_lat2_valid", out_valid, 1);
      check("add_res", out_result, {16'h0000, 16'h000A, 16'h0000, 16'h0003});
      check("add_zero", out_zero, 4'b1010);
      check("add_tag", out_tag, 4'd1);
      @(posedge clk); #1;

      send(4'd1, 4'b0101, rep(16'h7), rep(16'h7), 4'd2);
      expect_out("mask_sub", '0, 4'b0101, 1'b0, 4'd2);
      send(4'd14, 4'hF, rep(16'h1234), rep(16'h0001), 4'd9);
      expect_out("illegal", '0, 4'b0000, 1'b1, 4'd9);
      send(4'd9, 4'hF, rep(16'h8000), rep(16'h0001), 4'd3);
      expect_out("slt", rep(16'h0001), 4'b0000, 1'b0, 4'd3);
      send(4'd10, 4'hF, rep(16'h8000), rep(16'h0001), 4'd4);
      expect_out("sltu", '0, 4'b1111, 1'b0, 4'd4);
      send(4'd11, 4'hF, rep(16'h8000), rep(16'h0001), 4'd5);
      expect_out("min", rep(16'h8000), 4'b0000, 1'b0, 4'd5);
      send(4'd12, 4'hF, rep(16'h8000), rep(16'h0001), 4'd6);
      expect_out("max", rep(16'h0001), 4'b0000, 1'b0, 4'd6);
      send(4'd8, 4'hF, rep(16'h8000), rep(16'h0004), 4'd7);
      expect_out("sra", rep(16'hF800), 4'b0000, 1'b0, 4'd7);
      send(4'd7, 4'hF, rep(16'h8000), rep(16'h0004), 4'd8);
      expect_out("srl", rep(16'h0800), 4'b0000, 1'b0, 4'd8);
      send(4'd6, 4'hF, rep(16'h4001), rep(16'h0011), 4'd10);
      expect_out("sll", rep(16'h8002), 4'b0000, 1'b0, 4'd10);
      send(4'd2, 4'hF, rep(16'h0100), rep(16'h0100), 4'd11);
      expect_out("mul", '0, 4'b1111, 1'b0, 4'd11);

      // Back-pressure: 5 back-to-back ops, consumer stalled for 4 cycles.
      out_ready = 1'b0;
      fork
         begin
            for (int t = 0; t < 5; t++) send(4'd0, 4'hF, rnd_vec(), rnd_vec(), TW'(t));
         end
         begin
            repeat (2) @(negedge clk);
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               check("bp_in_ready_low", in_ready, 0);
               check("bp_out_valid", out_valid, 1);
               check("bp_out_tag_held", out_tag, 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("bp_release_valid", out_valid, 1);
               check("bp_release_tag", out_tag, TW'(k));
            end
         end
      join
      @(posedge clk); #1;

      // Reset with both stages full; a new input is presented during reset.
      out_ready = 1'b0;
      send(4'd3, 4'hF, rnd_vec(), rnd_vec(), 4'd5);
      send(4'd4, 4'hF, rnd_vec(), rnd_vec(), 4'd6);
      in_valid = 1'b1; in_tag = 4'd7; in_op = 4'd0; in_mask = 4'hF;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_outputs", {out_result, out_zero, out_mask, out_tag, out_illegal}, 0);
      check("midrst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("midrst_no_output", out_valid, 0);
      end
      @(posedge clk); #1;

      // Randomized regression with random consumer back-pressure.
      rand_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 10000; n++) begin
               send(4'($urandom_range(0, 15)), NL'($urandom), rnd_vec(), rnd_vec(), TW'($urandom));
               if ($urandom_range(0, 7) == 0) begin
                  @(posedge clk); #1;
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
